// File: rtl/dsp_result_rx.sv
// Purpose: AXI-Stream sink for the (a+b)*c DSP results; FWFT FIFO to an AXIS master, plus per-frame sum/length stats.
// Latency: a word accepted at edge N appears on m_axis_* after edge N (1 cycle), with no same-cycle bypass.
// Backpressure: s_axis_ready drops only when the FIFO is full; optional DSP_RX_ACC_SAT_EN makes the frame sum saturate.
module dsp_result_rx #(
    parameter int data_width = 16,
    parameter int DEPTH      = 8,
    parameter int ACC_W      = 40,
    parameter int LEN_W      = 16
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  s_axis_valid,
    input  logic [2*data_width:0] s_axis_data,
    input  logic                  s_axis_last,
    output logic                  s_axis_ready,
    output logic                  m_axis_valid,
    output logic [2*data_width:0] m_axis_data,
    output logic                  m_axis_last,
    input  logic                  m_axis_ready,
    output logic                  frame_done,
    output logic [ACC_W-1:0]      frame_sum,
    output logic [LEN_W-1:0]      frame_len,
    output logic                  acc_sat
);

    localparam int DW = 2*data_width+1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // Each entry holds {last, data}.
    logic [DW:0]      mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    logic [ACC_W-1:0] acc;
    logic [LEN_W-1:0] len;
    logic [ACC_W-1:0] data_ext;
    logic [ACC_W-1:0] acc_next;

    // Ready depends only on registered occupancy so it never waits on upstream valid.
    assign s_axis_ready = en && (count != FULL_CNT);
    assign m_axis_valid = (count != '0);
    assign {m_axis_last, m_axis_data} = mem[rd_ptr];

    assign push     = s_axis_valid && s_axis_ready;
    assign pop      = m_axis_valid && m_axis_ready;
    assign data_ext = ACC_W'(s_axis_data);

`ifdef DSP_RX_ACC_SAT_EN
    logic [ACC_W:0] sum_full;
    logic           sat_now;
    logic           sat_flag;

    // One extra bit on the adder exposes the carry that triggers clamping.
    always_comb begin
        sum_full = {1'b0, acc} + {1'b0, data_ext};
        sat_now  = sum_full[ACC_W];
        acc_next = sat_now ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
    end
`else
    // Accumulator wraps modulo 2^ACC_W in this build.
    assign acc_next = acc + data_ext;
    assign acc_sat  = 1'b0;
`endif

    // FIFO storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!en) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {s_axis_last, s_axis_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Frame statistics follow the push side; the last word closes the frame and publishes results.
    always_ff @(posedge clk) begin
        if (!en) begin
            acc        <= '0;
            len        <= '0;
            frame_sum  <= '0;
            frame_len  <= '0;
            frame_done <= 1'b0;
`ifdef DSP_RX_ACC_SAT_EN
            sat_flag   <= 1'b0;
            acc_sat    <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            if (push) begin
                if (s_axis_last) begin
                    frame_sum  <= acc_next;
                    frame_len  <= len + 1'b1;
                    frame_done <= 1'b1;
                    acc        <= '0;
                    len        <= '0;
`ifdef DSP_RX_ACC_SAT_EN
                    acc_sat    <= sat_flag | sat_now;
                    sat_flag   <= 1'b0;
`endif
                end else begin
                    acc        <= acc_next;
                    len        <= len + 1'b1;
`ifdef DSP_RX_ACC_SAT_EN
                    sat_flag   <= sat_flag | sat_now;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_dsp_result_rx.sv
module tb_dsp_result_rx;

    localparam int DWID  = 8;
    localparam int DW    = 2*DWID+1;
    localparam int DEPTH = 4;
    localparam int ACC_W = 18;
    localparam int LEN_W = 16;
    localparam longint MAXV = (longint'(1) << ACC_W) - 1;

    typedef struct {
        longint sum;
        int     len;
        bit     sat;
    } frm_t;

    logic              clk = 1'b0;
    logic              en;
    logic              s_axis_valid;
    logic [DW-1:0]     s_axis_data;
    logic              s_axis_last;
    logic              s_axis_ready;
    logic              m_axis_valid;
    logic [DW-1:0]     m_axis_data;
    logic              m_axis_last;
    logic              m_axis_ready;
    logic              frame_done;
    logic [ACC_W-1:0]  frame_sum;
    logic [LEN_W-1:0]  frame_len;
    logic              acc_sat;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    logic [DW:0] dq [$];
    frm_t        fq [$];
    longint      cur_total = 0;
    int          cur_len   = 0;

    dsp_result_rx #(
        .data_width(DWID), .DEPTH(DEPTH), .ACC_W(ACC_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .en(en),
        .s_axis_valid(s_axis_valid), .s_axis_data(s_axis_data),
        .s_axis_last(s_axis_last), .s_axis_ready(s_axis_ready),
        .m_axis_valid(m_axis_valid), .m_axis_data(m_axis_data),
        .m_axis_last(m_axis_last), .m_axis_ready(m_axis_ready),
        .frame_done(frame_done), .frame_sum(frame_sum),
        .frame_len(frame_len), .acc_sat(acc_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected published frame: saturating sum is monotone, so clamp the exact total once.
    function automatic frm_t make_frame(input longint total, input int n);
        frm_t f;
`ifdef DSP_RX_ACC_SAT_EN
        f.sum = (total > MAXV) ? MAXV : total;
        f.sat = (total > MAXV);
`else
        f.sum = total % (MAXV + 1);
        f.sat = 1'b0;
`endif
        f.len = n % (1 << LEN_W);
        return f;
    endfunction

    // Monitor and scoreboard: sample mid-cycle, the handshakes seen here happen at the next rising edge.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [DW:0] w;
            frm_t f;
            chk("s_axis_ready", s_axis_ready, (en && dq.size() != DEPTH));
            chk("m_axis_valid", m_axis_valid, (dq.size() != 0));
            if (frame_done) begin
                chk("frame_expected", (fq.size() != 0), 1);
                if (fq.size() != 0) begin
                    f = fq.pop_front();
                    chk("frame_sum", frame_sum, f.sum);
                    chk("frame_len", frame_len, f.len);
                    chk("acc_sat", acc_sat, f.sat);
                end
            end
            if (!en) begin
                dq.delete();
                cur_total = 0;
                cur_len   = 0;
            end else begin
                if (m_axis_valid && m_axis_ready && dq.size() != 0) begin
                    w = dq.pop_front();
                    chk("m_axis_word", {m_axis_last, m_axis_data}, w);
                end
                if (s_axis_valid && s_axis_ready) begin
                    dq.push_back({s_axis_last, s_axis_data});
                    cur_total += longint'(s_axis_data);
                    cur_len++;
                    if (s_axis_last) begin
                        fq.push_back(make_frame(cur_total, cur_len));
                        cur_total = 0;
                        cur_len   = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        int n = 0;
        s_axis_valid = 1'b1;
        s_axis_data  = d;
        s_axis_last  = l;
        while (!s_axis_ready && n < 50) begin
            tick();
            n++;
        end
        chk("send_timeout", (n < 50), 1);
        tick();
        s_axis_valid = 1'b0;
    endtask

    initial begin
        en           = 1'b0;
        s_axis_valid = 1'b1;
        s_axis_data  = 17'h55;
        s_axis_last  = 1'b1;
        m_axis_ready = 1'b0;

        // Reset held for two cycles with upstream valid asserted.
        tick();
        mon_en = 1'b1;
        tick();
        chk("rst_s_ready", s_axis_ready, 0);
        chk("rst_m_valid", m_axis_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_sum", frame_sum, 0);
        chk("rst_frame_len", frame_len, 0);
        chk("rst_acc_sat", acc_sat, 0);

        en           = 1'b1;
        s_axis_valid = 1'b0;
        m_axis_ready = 1'b1;
        tick();
        chk("post_rst_empty", m_axis_valid, 0);

        // Basic frame 3,5,7.
        send(17'd3, 1'b0);
        send(17'd5, 1'b0);
        send(17'd7, 1'b1);
        tick();
        tick();
        chk("frame1_sum", frame_sum, 15);
        chk("frame1_len", frame_len, 3);

        // Fill the FIFO with the sink stalled, then release it.
        m_axis_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(17'(20 + i), 1'b0);
        s_axis_valid = 1'b1;
        s_axis_data  = 17'd24;
        s_axis_last  = 1'b0;
        tick();
        tick();
        chk("full_ready_low", s_axis_ready, 0);
        m_axis_ready = 1'b1;
        send(17'd24, 1'b0);
        send(17'd25, 1'b1);
        for (int i = 0; i < 8; i++) tick();

        // Simultaneous push/pop at occupancy 2, wrapping pointers.
        m_axis_ready = 1'b0;
        send(17'd1, 1'b0);
        send(17'd2, 1'b0);
        m_axis_ready = 1'b1;
        s_axis_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            s_axis_data = 17'(3 + k);
            s_axis_last = (k == 7);
            tick();
        end
        s_axis_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Reset in the middle of a frame drops the partial frame.
        m_axis_ready = 1'b0;
        send(17'd100, 1'b0);
        send(17'd200, 1'b0);
        en = 1'b0;
        tick();
        en = 1'b1;
        m_axis_ready = 1'b1;
        send(17'd10, 1'b1);
        tick();
        tick();
        chk("midrst_sum", frame_sum, 10);
        chk("midrst_len", frame_len, 1);

        // Three maximal words to exercise overflow handling.
        send(17'h1FFFF, 1'b0);
        send(17'h1FFFF, 1'b0);
        send(17'h1FFFF, 1'b1);
        tick();
        tick();
`ifdef DSP_RX_ACC_SAT_EN
        chk("sat_sum", frame_sum, 18'h3FFFF);
        chk("sat_flag", acc_sat, 1);
`else
        chk("sat_sum", frame_sum, 18'h1FFFD);
        chk("sat_flag", acc_sat, 0);
`endif

        // Randomized traffic with random backpressure and rare resets.
        for (int c = 0; c < 600; c++) begin
            en           = ($urandom_range(0, 79) != 0);
            s_axis_valid = $urandom_range(0, 2) != 0;
            s_axis_data  = ($urandom_range(0, 3) == 0) ? 17'(17'h1FF00 + $urandom_range(0, 255))
                                                       : 17'($urandom_range(0, 1000));
            s_axis_last  = ($urandom_range(0, 3) == 0);
            m_axis_ready = $urandom_range(0, 1) != 0;
            tick();
        end

        // Drain whatever is left.
        en           = 1'b1;
        s_axis_valid = 1'b0;
        m_axis_ready = 1'b1;
        for (int i = 0; i < 20 && m_axis_valid; i++) tick();
        tick();
        tick();
        chk("drain_empty", dq.size(), 0);
        chk("frames_pending", fq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
